amp_sample_scaler: RTL and testbench
====================================

# amp_sample_scaler

Downstream stage of the amplitude min/max controls. Takes raw full-scale 12-bit waveform samples from the waveform generator and maps each one linearly into the user-selected window [MIN_AMP, MAX_AMP]. It then presents the result to the DAC output interface. Scaling uses a multi-cycle shift-add multiplier with a valid/ready handshake on both sides of the block.

## Interface
Parameters:
- WIDTH, 12, sample and DAC data width; amplitude full scale is 2^WIDTH-1 = 4095.

Ports:
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SAMPLE  in  12  raw waveform sample, 0 = bottom of window, 4095 = top of window.
- SAMPLE_VALID  in  1  SAMPLE is valid this cycle.
- SAMPLE_READY  out  1  block can accept a sample this cycle.
- MAX_AMP  in  32  upper amplitude bound from the max control.
- MIN_AMP  in  32  lower amplitude bound from the min control.
- DAC_DATA  out  12  scaled sample, held until the next result.
- DAC_VALID  out  1  one-cycle strobe marking a new DAC_DATA value.

## Operation
- States:
  - IDLE → MUL on the handshake, SAMPLE_VALID && SAMPLE_READY.
  - MUL: 13 iterations, then DONE.
  - DONE: 1 cycle, then IDLE.
- SAMPLE_READY = (state == IDLE) && !RESET.
- On handshake the block latches:
  - s = SAMPLE + 1, 13 bits, range 1..4096.
  - lo = min(MIN_AMP, 4095).
  - hi = min(MAX_AMP, 4095).
  - span = (hi >= lo) ? hi − lo : 0, 12 bits.
- Because all bounds are latched at the handshake, MIN_AMP/MAX_AMP changes during MUL or DONE do not affect the in-flight result.
- MUL: unsigned shift-add of span × s into a 25-bit accumulator, one multiplier bit per cycle, LSB first, 13 cycles. An iteration counter 0..12 ends MUL on count 12.
- Result = lo + product[24:12].
  - Sample 4095 yields exactly hi; sample 0 yields lo.
  - The sum is ≤ hi ≤ 4095, so there is no overflow and no saturation logic.
- If MAX_AMP < MIN_AMP after clamping, span = 0 and the result is lo.
- DONE: DAC_DATA ← result, DAC_VALID = 1 for that single cycle.
- DAC_DATA is otherwise held; it is never cleared except by RESET.
- SAMPLE_VALID while not ready is ignored. SAMPLE is not buffered; upstream holds SAMPLE_VALID until accepted.

## Timing
- Reset values:
  - state = IDLE, DAC_DATA = 0, DAC_VALID = 0.
  - Accumulator and counter = 0.
  - SAMPLE_READY = 0 while RESET is high and 1 the first cycle after release.
- Handshake at cycle N:
  - MUL occupies cycles N+1..N+13.
  - DAC_VALID = 1 and DAC_DATA updated at cycle N+14.
  - SAMPLE_READY returns high at cycle N+15.
- Latency from accepted sample to DAC_VALID: 14 cycles. Maximum throughput: 1 sample per 15 cycles.
- SAMPLE_READY is low from N+1 through N+14 inclusive.
- RESET mid-MUL or in DONE: the operation is aborted, no DAC_VALID is issued, and all registers return to reset values on the next edge.
- RESET together with SAMPLE_VALID: the sample is not accepted.
- Back-to-back: SAMPLE_VALID held high continuously gives handshakes at N, N+15, N+30, …

## Test plan
- Reset release, then SAMPLE = 4095, MIN_AMP = 0, MAX_AMP = 4095, valid at cycle N → DAC_VALID pulse at N+14 with DAC_DATA = 4095; SAMPLE_READY low N+1..N+14 and high at N+15.
- SAMPLE = 0, MIN_AMP = 100, MAX_AMP = 4095 → DAC_DATA = 100.
- SAMPLE = 2047, MIN_AMP = 1000, MAX_AMP = 3000 → span 2000, product >> 12 = 1000, DAC_DATA = 2000.
- Clamp and invert cases:
  - MAX_AMP = 5000, MIN_AMP = 0, SAMPLE = 4095 → DAC_DATA = 4095.
  - MAX_AMP = 50, MIN_AMP = 300, SAMPLE = 3000 → DAC_DATA = 300.
- SAMPLE = 4095, MIN_AMP = 0, MAX_AMP = 2000; change MAX_AMP to 4095 at N+5 → DAC_DATA = 2000; a continuous-valid stream then shows handshakes exactly 15 cycles apart.
- Handshake at N, RESET high at N+7 for 1 cycle → no DAC_VALID at N+14, DAC_DATA = 0, SAMPLE_READY = 1 at N+8.

Source files
------------

// File: rtl/amp_sample_scaler_if.sv
// Sample-in / DAC-out bus for amp_sample_scaler.
// master drives samples and amplitude bounds; slave is the scaler.
interface amp_sample_scaler_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] SAMPLE;
    logic             SAMPLE_VALID;
    logic             SAMPLE_READY;
    logic [31:0]      MAX_AMP;
    logic [31:0]      MIN_AMP;
    logic [WIDTH-1:0] DAC_DATA;
    logic             DAC_VALID;

    modport master (
        output SAMPLE, SAMPLE_VALID, MAX_AMP, MIN_AMP,
        input  SAMPLE_READY, DAC_DATA, DAC_VALID
    );

    modport slave (
        input  SAMPLE, SAMPLE_VALID, MAX_AMP, MIN_AMP,
        output SAMPLE_READY, DAC_DATA, DAC_VALID
    );
endinterface

// File: rtl/amp_sample_scaler.sv
// Maps a full-scale sample linearly into the window [MIN_AMP, MAX_AMP]
// using a serial shift-add multiplier: result = lo + ((hi-lo)*(sample+1) >> WIDTH).
// One sample accepted per WIDTH+3 cycles; DAC_VALID strobes once per result.
module amp_sample_scaler #(
    parameter int WIDTH = 12
) (
    input  logic               CLOCK,
    input  logic               RESET,
    amp_sample_scaler_if.slave bus
);

    localparam int          CNT_W      = $clog2(WIDTH + 1);
    localparam logic [31:0] FULL_SCALE = 32'((2 ** WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2*WIDTH:0]   mcand_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH:0]     mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dac_data_q;
    logic               dac_valid_q;

    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   span_d;
    logic [2*WIDTH:0]   acc_d;
    logic [WIDTH-1:0]   result_d;
    logic               accept;

    assign bus.SAMPLE_READY = (state_q == IDLE) && !RESET;
    assign bus.DAC_DATA     = dac_data_q;
    assign bus.DAC_VALID    = dac_valid_q;
    assign accept           = bus.SAMPLE_VALID && bus.SAMPLE_READY;

    // Clamp the bounds to full scale and form the window span (0 if inverted).
    always_comb begin
        lo_d   = (bus.MIN_AMP > FULL_SCALE) ? FULL_SCALE[WIDTH-1:0] : bus.MIN_AMP[WIDTH-1:0];
        hi_d   = (bus.MAX_AMP > FULL_SCALE) ? FULL_SCALE[WIDTH-1:0] : bus.MAX_AMP[WIDTH-1:0];
        span_d = (hi_d >= lo_d) ? (hi_d - lo_d) : '0;
    end

    // One shift-add step and the final offset; the top product bits never exceed span,
    // so lo + product[2W:W] stays within full scale.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        result_d = WIDTH'({1'b0, lo_q} + acc_d[2*WIDTH:WIDTH]);
    end

    // Control FSM and datapath: latch operands on handshake, iterate, publish result.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dac_valid_q <= 1'b0;
                    if (accept) begin
                        lo_q     <= lo_d;
                        mcand_q  <= {{(WIDTH + 1){1'b0}}, span_d};
                        mplier_q <= {1'b0, bus.SAMPLE} + (WIDTH + 1)'(1);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        dac_data_q  <= result_d;
                        dac_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    dac_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    dac_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amp_sample_scaler.sv
// Scoreboard bench for amp_sample_scaler: the driver pushes expected
// {data, cycle} at each handshake; a negedge monitor pops and compares on DAC_VALID.
module tb_amp_sample_scaler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [11:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    amp_sample_scaler_if #(.WIDTH(12)) bus ();

    amp_sample_scaler #(.WIDTH(12)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a sample; wait (bounded) for acceptance and record the expected result.
    task automatic send(input logic [11:0] s, input logic [31:0] mn, input logic [31:0] mx,
                        input logic [11:0] exp, input bit hold, output int unsigned n);
        int unsigned waited;
        waited = 0;
        n = 0;
        bus.SAMPLE       = s;
        bus.MIN_AMP      = mn;
        bus.MAX_AMP      = mx;
        bus.SAMPLE_VALID = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.SAMPLE_READY) break;
            waited++;
            if (waited > 40) begin
                chk("handshake_timeout", 0, 1);
                bus.SAMPLE_VALID = 1'b0;
                return;
            end
        end
        n = cyc;
        sb.push_back('{data: exp, cyc: cyc + 14});
        @(posedge clk);
        #1;
        if (!hold) bus.SAMPLE_VALID = 1'b0;
    endtask

    // Monitor: every DAC_VALID strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.DAC_VALID) begin
            if (sb.size() == 0) begin
                chk("unexpected_dac_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dac_data", bus.DAC_DATA, e.data);
                chk("dac_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n;
        int unsigned hs[4];
        int          bad;
        int          seen;
        int          waited;

        // Reset with a valid sample pending: nothing may be accepted.
        bus.SAMPLE       = 12'd4095;
        bus.MIN_AMP      = 32'd0;
        bus.MAX_AMP      = 32'd4095;
        bus.SAMPLE_VALID = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", bus.SAMPLE_READY, 0);
        chk("reset_dac_valid", bus.DAC_VALID, 0);
        chk("reset_dac_data", bus.DAC_DATA, 0);
        @(posedge clk);
        #1;
        bus.SAMPLE_VALID = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", bus.SAMPLE_READY, 1);
        @(posedge clk);
        #1;

        // Full scale, full window; also check the busy window of SAMPLE_READY.
        send(12'd4095, 32'd0, 32'd4095, 12'd4095, 1'b0, n);
        bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.SAMPLE_READY || cyc != n + k) bad++;
        end
        chk("ready_low_n1_n14", bad, 0);
        @(negedge clk);
        chk("ready_high_n15", bus.SAMPLE_READY, 1);
        chk("ready_high_cycle", cyc, n + 15);
        @(posedge clk);
        #1;

        send(12'd0,    32'd100,  32'd4095, 12'd100,  1'b0, n);
        send(12'd2047, 32'd1000, 32'd3000, 12'd2000, 1'b0, n);
        send(12'd4095, 32'd0,    32'd5000, 12'd4095, 1'b0, n);
        send(12'd3000, 32'd300,  32'd50,   12'd300,  1'b0, n);

        // Bounds change mid-multiply must not affect the in-flight result.
        send(12'd4095, 32'd0, 32'd2000, 12'd2000, 1'b0, n);
        repeat (4) @(posedge clk);
        #1;
        bus.MAX_AMP = 32'd4095;

        // Continuous valid: handshakes every 15 cycles.
        for (int i = 0; i < 4; i++) begin
            send(12'd4095, 32'd0, 32'd4095, 12'd4095, 1'b1, hs[i]);
        end
        bus.SAMPLE_VALID = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("stream_spacing", hs[i] - hs[i-1], 15);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #1;

        // Reset mid-multiply aborts the operation.
        send(12'd1234, 32'd0, 32'd4095, 12'd1234, 1'b0, n);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_n8", bus.SAMPLE_READY, 1);
        chk("abort_ready_cycle", cyc, n + 8);
        chk("abort_dac_data", bus.DAC_DATA, 0);
        seen = 0;
        while (cyc <= n + 16) begin
            if (bus.DAC_VALID) seen = 1;
            @(negedge clk);
        end
        chk("abort_no_dac_valid", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
